// File: rtl/instr_fetch_reg_if.sv
// instr_fetch_reg_if: fetch request, instruction memory and decoded IR bundle for instr_fetch_reg.
interface instr_fetch_reg_if;
    logic        fetch_start;
    logic [63:0] pc;
    logic        mem_rd;
    logic [63:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] instrucao;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [3:0]  indica_immediate;
    logic        ir_valid;
    logic        illegal;
    logic        misaligned;
    logic        busy;
    logic        halt;

    modport master (
        output fetch_start, pc, mem_data,
        input  mem_rd, mem_addr, instrucao, opcode, rd, funct3, rs1, rs2, funct7,
               indica_immediate, ir_valid, illegal, misaligned, busy, halt
    );

    modport slave (
        input  fetch_start, pc, mem_data,
        output mem_rd, mem_addr, instrucao, opcode, rd, funct3, rs1, rs2, funct7,
               indica_immediate, ir_valid, illegal, misaligned, busy, halt
    );
endinterface

// File: rtl/instr_fetch_reg.sv
// instr_fetch_reg: multicycle fetch stage and instruction register feeding the immediate sign-extender.
// Optional IR_HALT_DETECT_EN: a fetched all-zero word sets a sticky halt that blocks further fetches.
module instr_fetch_reg #(
    parameter int MEM_LATENCY = 1
) (
    input logic             clk,
    input logic             reset,
    instr_fetch_reg_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_ir;
    logic [63:0] r_mem_addr;
    logic [3:0]  r_imm;
    logic        r_illegal;
    logic        r_misaligned;
    logic        w_block;
    logic        w_start;
    logic        w_accept;
    logic        w_sample;
    logic [3:0]  w_imm;
    logic        w_illegal;

    assign w_start  = r_state == IDLE && bus.fetch_start && !w_block;
    assign w_accept = w_start && bus.pc[1:0] == 2'b00;
    assign w_sample = r_state == WAIT && r_cnt == 4'd1;

    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? REQ : IDLE;
            REQ:     w_next = WAIT;
            WAIT:    w_next = w_sample ? DONE : WAIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Immediate-type selector decoded from the incoming word so it registers alongside the IR.
    always_comb begin
        w_imm     = 4'd0;
        w_illegal = 1'b0;
        case (bus.mem_data[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: w_imm = 4'd1;
            7'b1100011: w_imm = 4'd2;
            7'b0110111: w_imm = 4'd3;
            7'b0100011: w_imm = 4'd4;
            7'b1101111: w_imm = 4'd5;
            7'b0110011: w_imm = 4'd0;
            default:    w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_ir         <= 32'd0;
            r_mem_addr   <= 64'd0;
            r_imm        <= 4'd0;
            r_illegal    <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_start && bus.pc[1:0] != 2'b00;
            if (w_accept)
                r_mem_addr <= bus.pc;
            if (r_state == REQ)
                r_cnt <= 4'(MEM_LATENCY);
            else if (r_state == WAIT)
                r_cnt <= r_cnt - 4'd1;
            if (w_sample) begin
                r_ir      <= bus.mem_data;
                r_imm     <= w_imm;
                r_illegal <= w_illegal;
            end
        end
    end

`ifdef IR_HALT_DETECT_EN
    logic r_halt;

    always_ff @(posedge clk) begin
        r_halt <= reset ? 1'b0 : r_halt | (w_sample && bus.mem_data == 32'd0);
    end

    assign w_block = r_halt;
`else
    assign w_block = 1'b0;
`endif

    assign bus.halt             = w_block;
    assign bus.mem_rd           = r_state == REQ;
    assign bus.ir_valid         = r_state == DONE;
    assign bus.busy             = r_state != IDLE;
    assign bus.mem_addr         = r_mem_addr;
    assign bus.misaligned       = r_misaligned;
    assign bus.instrucao        = r_ir;
    assign bus.indica_immediate = r_imm;
    assign bus.illegal          = r_illegal;
    assign bus.opcode           = r_ir[6:0];
    assign bus.rd               = r_ir[11:7];
    assign bus.funct3           = r_ir[14:12];
    assign bus.rs1              = r_ir[19:15];
    assign bus.rs2              = r_ir[24:20];
    assign bus.funct7           = r_ir[31:25];
endmodule

// File: tb/tb_instr_fetch_reg.sv
// tb_instr_fetch_reg: two fetch stages (MEM_LATENCY 1 and 3) driven by latency-accurate memory models;
// expected IR/selector/illegal triples are queued per fetch and compared when ir_valid pulses.
module tb_instr_fetch_reg;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] mq_a[$];
    logic [31:0] mq_b[$];
    logic [36:0] eq_a[$];
    logic [36:0] eq_b[$];

`ifdef IR_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    instr_fetch_reg_if a ();
    instr_fetch_reg_if b ();

    instr_fetch_reg #(.MEM_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
    instr_fetch_reg #(.MEM_LATENCY(3)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));

    always #5 clk = ~clk;

    // Memory A: word valid exactly 1 cycle after the mem_rd cycle, random garbage otherwise.
    initial begin
        int d;
        logic [31:0] w;
        d = 100;
        w = 32'd0;
        a.mem_data = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (a.mem_rd) begin
                d = 0;
                if (mq_a.size() > 0) w = mq_a.pop_front();
                else w = 32'hDEADBEEF;
            end else if (d < 100) d++;
            a.mem_data = (d == 1) ? w : $urandom;
        end
    end

    // Memory B: word valid exactly 3 cycles after the mem_rd cycle.
    initial begin
        int d;
        logic [31:0] w;
        d = 100;
        w = 32'd0;
        b.mem_data = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (b.mem_rd) begin
                d = 0;
                if (mq_b.size() > 0) w = mq_b.pop_front();
                else w = 32'hDEADBEEF;
            end else if (d < 100) d++;
            b.mem_data = (d == 3) ? w : $urandom;
        end
    end

    task automatic test_reset;
        checks++;
        if ({a.instrucao, a.opcode, a.rd, a.funct3, a.rs1, a.rs2, a.funct7, a.indica_immediate, a.mem_addr,
             a.mem_rd, a.ir_valid, a.illegal, a.misaligned, a.halt, a.busy} !== 153'd0) begin
            failures++;
            $display("FAIL reset_a ir=%h imm=%0d addr=%h rd=%b v=%b ill=%b mis=%b halt=%b busy=%b, all must be 0",
                     a.instrucao, a.indica_immediate, a.mem_addr, a.mem_rd, a.ir_valid, a.illegal, a.misaligned, a.halt, a.busy);
        end
        checks++;
        if ({b.instrucao, b.opcode, b.rd, b.funct3, b.rs1, b.rs2, b.funct7, b.indica_immediate, b.mem_addr,
             b.mem_rd, b.ir_valid, b.illegal, b.misaligned, b.halt, b.busy} !== 153'd0) begin
            failures++;
            $display("FAIL reset_b ir=%h imm=%0d addr=%h rd=%b v=%b ill=%b mis=%b halt=%b busy=%b, all must be 0",
                     b.instrucao, b.indica_immediate, b.mem_addr, b.mem_rd, b.ir_valid, b.illegal, b.misaligned, b.halt, b.busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_addi;
        logic [36:0] e;
        int n;
        int rdn;
        mq_a.push_back(32'hFFF10093);
        eq_a.push_back({32'hFFF10093, 4'd1, 1'b0});
        @(negedge clk);
        a.fetch_start = 1'b1;
        a.pc = 64'h40;
        @(negedge clk);
        a.fetch_start = 1'b0;
        checks++;
        if ({a.mem_rd, a.mem_addr, a.busy} !== {1'b1, 64'h40, 1'b1}) begin
            failures++;
            $display("FAIL addi_req got rd=%b addr=%h busy=%b exp rd=1 addr=40 busy=1", a.mem_rd, a.mem_addr, a.busy);
        end
        n = 1;
        rdn = 0;
        while (!a.ir_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (a.mem_rd) rdn++;
        end
        checks++;
        if (n !== 3 || rdn !== 0) begin
            failures++;
            $display("FAIL addi_latency got %0d cycles, %0d extra mem_rd; exp 3 cycles, 0 extra", n, rdn);
        end
        e = (eq_a.size() > 0) ? eq_a.pop_front() : 'x;
        checks++;
        if ({a.instrucao, a.indica_immediate, a.illegal} !== e) begin
            failures++;
            $display("FAIL addi_ir got %h/%0d/%b exp %h/%0d/%b", a.instrucao, a.indica_immediate, a.illegal, e[36:5], e[4:1], e[0]);
        end
        checks++;
        if ({a.funct7, a.rs2, a.rs1, a.funct3, a.rd, a.opcode} !== {7'h7F, 5'd31, 5'd2, 3'd0, 5'd1, 7'h13}) begin
            failures++;
            $display("FAIL addi_fields got f7=%h rs2=%0d rs1=%0d f3=%0d rd=%0d op=%h exp 7f/31/2/0/1/13",
                     a.funct7, a.rs2, a.rs1, a.funct3, a.rd, a.opcode);
        end
        @(negedge clk);
        checks++;
        if ({a.ir_valid, a.busy} !== 2'b00) begin
            failures++;
            $display("FAIL addi_pulse got valid=%b busy=%b exp 0 0", a.ir_valid, a.busy);
        end
    endtask

    task automatic test_misaligned;
        int rdn;
        @(negedge clk);
        a.fetch_start = 1'b1;
        a.pc = 64'h42;
        @(negedge clk);
        a.fetch_start = 1'b0;
        checks++;
        if ({a.misaligned, a.mem_rd, a.busy, a.mem_addr, a.instrucao} !== {3'b100, 64'h40, 32'hFFF10093}) begin
            failures++;
            $display("FAIL misaligned_pulse got mis=%b rd=%b busy=%b addr=%h ir=%h exp 1 0 0 40 fff10093",
                     a.misaligned, a.mem_rd, a.busy, a.mem_addr, a.instrucao);
        end
        rdn = 0;
        repeat (4) begin
            @(negedge clk);
            if (a.mem_rd || a.busy || a.misaligned) rdn++;
        end
        checks++;
        if (rdn !== 0) begin
            failures++;
            $display("FAIL misaligned_after got %0d active cycles exp 0", rdn);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words[4] = '{32'h00208463, 32'h123452B7, 32'h00113423, 32'h008000EF};
        logic [3:0] imms[4] = '{4'd2, 4'd3, 4'd4, 4'd5};
        logic [36:0] e;
        int n;
        for (int i = 0; i < 4; i++) begin
            mq_b.push_back(words[i]);
            eq_b.push_back({words[i], imms[i], 1'b0});
            @(negedge clk);
            b.fetch_start = 1'b1;
            b.pc = 64'h100 + 64'(4 * i);
            @(negedge clk);
            b.fetch_start = 1'b0;
            checks++;
            if ({b.mem_rd, b.mem_addr} !== {1'b1, 64'h100 + 64'(4 * i)}) begin
                failures++;
                $display("FAIL b2b_req[%0d] got rd=%b addr=%h exp rd=1 addr=%h", i, b.mem_rd, b.mem_addr, 64'h100 + 64'(4 * i));
            end
            n = 1;
            while (!b.ir_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n !== 5) begin
                failures++;
                $display("FAIL b2b_latency[%0d] got %0d cycles exp 5", i, n);
            end
            e = (eq_b.size() > 0) ? eq_b.pop_front() : 'x;
            checks++;
            if ({b.instrucao, b.indica_immediate, b.illegal} !== e) begin
                failures++;
                $display("FAIL b2b_ir[%0d] got %h/%0d/%b exp %h/%0d/%b", i, b.instrucao, b.indica_immediate, b.illegal,
                         e[36:5], e[4:1], e[0]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [36:0] e;
        int n;
        mq_b.push_back(32'h00A00513);
        @(negedge clk);
        b.fetch_start = 1'b1;
        b.pc = 64'h200;
        @(negedge clk);
        b.fetch_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({b.busy, b.mem_rd, b.ir_valid, b.instrucao, b.indica_immediate, b.illegal, b.mem_addr} !== 103'd0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b rd=%b v=%b ir=%h imm=%0d ill=%b addr=%h exp all 0",
                     b.busy, b.mem_rd, b.ir_valid, b.instrucao, b.indica_immediate, b.illegal, b.mem_addr);
        end
        reset = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (b.ir_valid || b.mem_rd) n++;
        end
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL reset_mid_ghost got %0d pulses exp 0", n);
        end
        mq_b.push_back(32'h00A00513);
        eq_b.push_back({32'h00A00513, 4'd1, 1'b0});
        b.fetch_start = 1'b1;
        b.pc = 64'h204;
        @(negedge clk);
        b.fetch_start = 1'b0;
        n = 1;
        while (!b.ir_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = (eq_b.size() > 0) ? eq_b.pop_front() : 'x;
        checks++;
        if (n !== 5 || {b.instrucao, b.indica_immediate, b.illegal} !== e) begin
            failures++;
            $display("FAIL reset_mid_refetch got %0d cycles %h/%0d/%b exp 5 cycles %h/%0d/%b", n,
                     b.instrucao, b.indica_immediate, b.illegal, e[36:5], e[4:1], e[0]);
        end
    endtask

    task automatic test_held_start;
        logic [36:0] e;
        int n;
        int rdn;
        mq_a.push_back(32'h0000007F);
        eq_a.push_back({32'h0000007F, 4'd0, 1'b1});
        @(negedge clk);
        a.fetch_start = 1'b1;
        a.pc = 64'h300;
        n = 0;
        rdn = 0;
        while (!a.ir_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (a.mem_rd) rdn++;
        end
        a.fetch_start = 1'b0;
        e = (eq_a.size() > 0) ? eq_a.pop_front() : 'x;
        checks++;
        if ({a.instrucao, a.indica_immediate, a.illegal} !== e) begin
            failures++;
            $display("FAIL held_ir got %h/%0d/%b exp %h/%0d/%b", a.instrucao, a.indica_immediate, a.illegal,
                     e[36:5], e[4:1], e[0]);
        end
        repeat (4) begin
            @(negedge clk);
            if (a.mem_rd) rdn++;
        end
        checks++;
        if (rdn !== 1) begin
            failures++;
            $display("FAIL held_mem_rd got %0d strobes exp 1", rdn);
        end
    endtask

    task automatic test_halt;
        logic [36:0] e;
        int n;
        int rdn;
        mq_a.push_back(32'h00000000);
        eq_a.push_back({32'h00000000, 4'd0, 1'b1});
        @(negedge clk);
        a.fetch_start = 1'b1;
        a.pc = 64'h400;
        @(negedge clk);
        a.fetch_start = 1'b0;
        n = 1;
        while (!a.ir_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = (eq_a.size() > 0) ? eq_a.pop_front() : 'x;
        checks++;
        if ({a.instrucao, a.indica_immediate, a.illegal, a.halt} !== {e, HALT_EN}) begin
            failures++;
            $display("FAIL halt_zero got %h/%0d/%b halt=%b exp %h/%0d/%b halt=%b", a.instrucao, a.indica_immediate,
                     a.illegal, a.halt, e[36:5], e[4:1], e[0], HALT_EN);
        end
        @(negedge clk);
        a.fetch_start = 1'b1;
        a.pc = 64'h404;
        @(negedge clk);
        a.fetch_start = 1'b0;
        rdn = a.mem_rd ? 1 : 0;
        repeat (5) begin
            @(negedge clk);
            if (a.mem_rd) rdn++;
        end
        checks++;
        if (rdn !== (HALT_EN ? 0 : 1) || a.halt !== HALT_EN) begin
            failures++;
            $display("FAIL halt_block got %0d strobes halt=%b exp %0d strobes halt=%b", rdn, a.halt, HALT_EN ? 0 : 1, HALT_EN);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (a.halt !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset got %b exp 0", a.halt);
        end
        a.fetch_start = 1'b1;
        a.pc = 64'h408;
        @(negedge clk);
        a.fetch_start = 1'b0;
        checks++;
        if ({a.mem_rd, a.mem_addr} !== {1'b1, 64'h408}) begin
            failures++;
            $display("FAIL halt_refetch got rd=%b addr=%h exp rd=1 addr=408", a.mem_rd, a.mem_addr);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        a.fetch_start = 1'b0;
        a.pc = 64'd0;
        b.fetch_start = 1'b0;
        b.pc = 64'd0;
        repeat (3) @(negedge clk);
        test_reset;
        test_addi;
        test_misaligned;
        test_back_to_back;
        test_reset_mid;
        test_held_start;
        test_halt;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
